// File: rtl/regfile.sv
// 32x32 register file: two combinational reads, one synchronous write, r0 = 0.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;

  assign wr_ok = we && (wa != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = mem[ra1];
    if (ra2 != '0) rd2 = mem[ra2];
`ifdef REGFILE_BYPASS_EN
    // wr_ok already excludes r0, so the zero register stays zero
    if (!rst && wr_ok && ra1 == wa) rd1 = wd;
    if (!rst && wr_ok && ra2 == wa) rd2 = wd;
`else
`endif
  end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: scoreboard queue, immediate-assertion checks.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;

  regfile dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .wa  (wa),
    .wd  (wd),
    .ra1 (ra1),
    .ra2 (ra2),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [32];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1;
    wa = a;
    wd = d;
    edge_step();
    we = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    edge_step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic read2(input string tag, input logic [4:0] a1,
                       input logic [4:0] a2);
    ra1 = a1;
    ra2 = a2;
    #1;
    push({tag, "_rd1"}, model[a1]);
    pop_cmp(rd1);
    push({tag, "_rd2"}, model[a2]);
    pop_cmp(rd2);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      read2(tag, 5'(i), 5'(31 - i));
    end
  endtask

  initial begin
    rst = 1'b1;
    we  = 1'b0;
    wa  = '0;
    wd  = '0;
    ra1 = '0;
    ra2 = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    do_reset();
    check_all("por");

    // reset clears written data
    do_write(5'd5, 32'hDEADBEEF);
    read2("r5_wr", 5'd5, 5'd5);
    do_reset();
    read2("r5_rst", 5'd5, 5'd0);
    check_all("rst");

    // basic writes
    do_write(5'd1, 32'h0000_0000);
    do_write(5'd2, 32'h0000_0FFF);
    do_write(5'd31, 32'hFFFF_FFFF);
    read2("basic", 5'd2, 5'd31);
    read2("basic_r1", 5'd1, 5'd1);

    // $zero stays zero
    do_write(5'd3, 32'hA5A5_A5A5);
    do_write(5'd0, 32'h1234_5678);
    read2("zero", 5'd0, 5'd3);
    check_all("zero_all");

    // write disabled
    we = 1'b0;
    wa = 5'd3;
    wd = 32'h1;
    edge_step();
    read2("we0", 5'd3, 5'd2);

    // reset beats simultaneous write
    do_write(5'd4, 32'h77);
    read2("r4_pre", 5'd4, 5'd4);
    rst = 1'b1;
    we  = 1'b1;
    wa  = 5'd4;
    wd  = 32'h55;
    edge_step();
    rst = 1'b0;
    we  = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    read2("rst_vs_wr", 5'd4, 5'd3);
    check_all("rst_vs_wr_all");

    // same-cycle read of write target
    do_write(5'd6, 32'h10);
    we  = 1'b1;
    wa  = 5'd6;
    wd  = 32'h20;
    ra1 = 5'd6;
    ra2 = 5'd0;
    #1;
`ifdef REGFILE_BYPASS_EN
    push("same_pre", 32'h20);
`else
    push("same_pre", 32'h10);
`endif
    pop_cmp(rd1);
    push("same_pre_r0", 32'h0);
    pop_cmp(rd2);
    edge_step();
    we = 1'b0;
    model[6] = 32'h20;
    read2("same_post", 5'd6, 5'd6);

    // write to r0 never forwards
    we  = 1'b1;
    wa  = 5'd0;
    wd  = 32'hCAFE_F00D;
    ra1 = 5'd0;
    ra2 = 5'd6;
    #1;
    push("wa0_fwd", 32'h0);
    pop_cmp(rd1);
    push("wa0_fwd_r6", 32'h20);
    pop_cmp(rd2);
    edge_step();
    we = 1'b0;

    // no forwarding while in reset
    rst = 1'b1;
    we  = 1'b1;
    wa  = 5'd6;
    wd  = 32'h99;
    ra1 = 5'd6;
    ra2 = 5'd6;
    #1;
    push("rst_nofwd", 32'h20);
    pop_cmp(rd1);
    push("rst_nofwd2", 32'h20);
    pop_cmp(rd2);
    edge_step();
    rst = 1'b0;
    we  = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    read2("rst_nofwd_post", 5'd6, 5'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
